// File: rtl/ef_sar_adc_seq_ctrl.sv
// ef_sar_adc_seq_ctrl
// Digital controller for a successive-approximation ADC with a channel
// sequencer and a show-ahead result FIFO.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   en              : block enable; dropping it aborts any conversion
//   clkdiv          : SAR tick divider (tick every clkdiv+1 cycles)
//   swidth          : sample phase length in ticks minus one
//   soc             : start of conversion, rising-edge sensitive
//   seq_en, seq     : sequencer mode and entry table {stop, channel} per entry
//   ch_sel_in       : channel used when seq_en=0
//   cmp             : comparator, 1 = input >= dac_data
//   sample_n        : 0 = track, 1 = hold
//   dac_data        : SAR trial word / final result
//   ch_sel_out      : analog mux select, latched when sampling starts
//   eoc             : one-cycle pulse in the DONE state
//   rd, data        : FIFO pop and show-ahead head {channel, result}
//   fifo_level/empty/full/threshold/above : FIFO status
//   ovf, ovf_clr    : sticky overrun flag and its clear
//   state_dbg       : current FSM state (0 IDLE, 1 SAMPLE, 2 CONVERT, 3 DONE)
//
// FIFO handshake: a push happens in every DONE cycle; rd pops the head only
// while fifo_empty=0 (rd on empty is ignored). A push into a full FIFO
// succeeds only when a pop happens in the same cycle; otherwise the sample
// is dropped and ovf is set.
module ef_sar_adc_seq_ctrl #(
  parameter int RES     = 10,
  parameter int CH_W    = 3,
  parameter int SEQ_N   = 8,
  parameter int FIFO_AW = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [7:0]                clkdiv,
  input  logic [3:0]                swidth,
  input  logic                      soc,
  input  logic                      seq_en,
  input  logic [SEQ_N*(CH_W+1)-1:0] seq,
  input  logic [CH_W-1:0]           ch_sel_in,
  input  logic                      cmp,
  output logic                      sample_n,
  output logic [RES-1:0]            dac_data,
  output logic [CH_W-1:0]           ch_sel_out,
  output logic                      eoc,
  input  logic                      rd,
  output logic [RES+CH_W-1:0]       data,
  output logic [FIFO_AW:0]          fifo_level,
  output logic                      fifo_empty,
  output logic                      fifo_full,
  input  logic [FIFO_AW:0]          fifo_threshold,
  output logic                      fifo_above,
  output logic                      ovf,
  input  logic                      ovf_clr,
  output logic [1:0]                state_dbg
);

  localparam int E     = CH_W + 1;
  localparam int IW    = $clog2(SEQ_N);
  localparam int BW    = $clog2(RES);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW    = RES + CH_W;
  localparam logic [RES-1:0] MSB = {1'b1, {(RES-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      div_cnt;
  logic            tick;
  logic            soc_q, soc_rise;
  logic [3:0]      samp_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [IW-1:0]   idx, idx_nxt;
  logic            cur_stop;
  logic [CH_W-1:0] ch_pick;

  assign soc_rise = soc & ~soc_q;
  assign tick     = ((state == S_SAMPLE) || (state == S_CONVERT)) && (div_cnt == clkdiv);
  assign cur_stop = seq[int'(idx)*E + CH_W];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (!en) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        S_IDLE:    if (soc_rise) state_nxt = S_SAMPLE;
        S_SAMPLE:  if (tick && (samp_cnt == swidth)) state_nxt = S_CONVERT;
        S_CONVERT: if (tick && (bit_cnt == '0)) state_nxt = S_DONE;
        S_DONE: begin
          if (!seq_en || cur_stop) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
          end else begin
            state_nxt = S_SAMPLE;
            idx_nxt   = (idx == IW'(SEQ_N-1)) ? '0 : idx + 1'b1;
          end
        end
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Channel for the SAMPLE phase being entered; uses the post-DONE index.
  assign ch_pick = seq_en ? seq[int'(idx_nxt)*E +: CH_W] : ch_sel_in;

  assign sample_n  = (state != S_SAMPLE);
  assign eoc       = (state == S_DONE);
  assign state_dbg = state;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      soc_q      <= 1'b0;
      div_cnt    <= '0;
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      idx        <= '0;
      dac_data   <= '0;
      ch_sel_out <= '0;
    end else begin
      soc_q <= soc;
      idx   <= idx_nxt;

      // Divider is held at zero in IDLE and DONE so every SAMPLE and
      // CONVERT phase starts on a fresh tick boundary.
      if ((state == S_SAMPLE) || (state == S_CONVERT))
        div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
      else
        div_cnt <= '0;

      if (state != S_SAMPLE) samp_cnt <= '0;
      else if (tick)         samp_cnt <= samp_cnt + 4'd1;

      if ((state != S_SAMPLE) && (state_nxt == S_SAMPLE))
        ch_sel_out <= ch_pick;

      if (!en) begin
        dac_data <= '0;
      end else if ((state == S_SAMPLE) && (state_nxt == S_CONVERT)) begin
        dac_data <= MSB;
        bit_cnt  <= BW'(RES-1);
      end else if ((state == S_CONVERT) && tick) begin
        // Resolve the current trial bit, then set the next lower trial bit.
        dac_data[bit_cnt] <= cmp;
        if (bit_cnt != '0) begin
          dac_data[bit_cnt - 1'b1] <= 1'b1;
          bit_cnt                  <= bit_cnt - 1'b1;
        end
      end
    end
  end

  // ---------------- result FIFO ----------------
  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               push, do_rd, do_wr;

  assign push       = (state == S_DONE);
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == (FIFO_AW+1)'(DEPTH));
  assign do_rd      = rd && !fifo_empty;
  assign do_wr      = push && (!fifo_full || do_rd);
  assign data       = fifo_empty ? '0 : mem[rd_ptr];
  assign fifo_above = (fifo_level > fifo_threshold);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {ch_sel_out, dac_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      // Set has priority over clear.
      if (push && fifo_full && !do_rd) ovf <= 1'b1;
      else if (ovf_clr)                ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ef_sar_adc_seq_ctrl.sv
// Directed testbench for ef_sar_adc_seq_ctrl. The analog side is modelled
// by an ideal comparator against a bench-held input voltage vin.
module tb_ef_sar_adc_seq_ctrl;
  localparam int RES     = 10;
  localparam int CH_W    = 3;
  localparam int SEQ_N   = 8;
  localparam int FIFO_AW = 4;
  localparam int DW      = RES + CH_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                      en, soc, seq_en, cmp, rd, ovf_clr;
  logic [7:0]                clkdiv;
  logic [3:0]                swidth;
  logic [SEQ_N*(CH_W+1)-1:0] seq;
  logic [CH_W-1:0]           ch_sel_in, ch_sel_out;
  logic                      sample_n, eoc, fifo_empty, fifo_full, fifo_above, ovf;
  logic [RES-1:0]            dac_data, vin;
  logic [DW-1:0]             data;
  logic [FIFO_AW:0]          fifo_level, fifo_threshold;
  logic [1:0]                state_dbg;

  assign cmp = (vin >= dac_data);

  ef_sar_adc_seq_ctrl #(.RES(RES), .CH_W(CH_W), .SEQ_N(SEQ_N), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clkdiv(clkdiv), .swidth(swidth),
    .soc(soc), .seq_en(seq_en), .seq(seq), .ch_sel_in(ch_sel_in), .cmp(cmp),
    .sample_n(sample_n), .dac_data(dac_data), .ch_sel_out(ch_sel_out), .eoc(eoc),
    .rd(rd), .data(data), .fifo_level(fifo_level), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_threshold(fifo_threshold), .fifo_above(fifo_above),
    .ovf(ovf), .ovf_clr(ovf_clr), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_soc();
    soc = 1'b1;
    step();
    soc = 1'b0;
  endtask

  // Counts observed busy cycles (and those with sample_n low) until eoc.
  task automatic wait_eoc(input int budget, output int busy, output int samp_low);
    busy = 0;
    samp_low = 0;
    while (!eoc && busy < budget) begin
      busy++;
      if (!sample_n) samp_low++;
      step();
    end
    if (!eoc) check_eq("eoc_timeout", eoc, 1);
  endtask

  task automatic pop_check(input string tag);
    logic [DW-1:0] e;
    e = exp_q.pop_front();
    check_eq(tag, data, e);
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_state"}, state_dbg, 0);
    check_eq({tag, "_sample_n"}, sample_n, 1);
    check_eq({tag, "_dac"}, dac_data, 0);
    check_eq({tag, "_ch"}, ch_sel_out, 0);
    check_eq({tag, "_eoc"}, eoc, 0);
    check_eq({tag, "_level"}, fifo_level, 0);
    check_eq({tag, "_empty"}, fifo_empty, 1);
    check_eq({tag, "_full"}, fifo_full, 0);
    check_eq({tag, "_data"}, data, 0);
    check_eq({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int busy, samp, cnt;
    rst_n = 1'b0; en = 1'b0; clkdiv = 8'd0; swidth = 4'd2; soc = 1'b0;
    seq_en = 1'b0; seq = '0; ch_sel_in = '0; rd = 1'b0; ovf_clr = 1'b0;
    fifo_threshold = 5'd5; vin = '0;
    step_n(3);
    check_reset_state("rst");
    rst_n = 1'b1;
    step();
    en = 1'b1;
    step();

    // Single channel, clkdiv=0: 3 sample cycles + 10 convert cycles.
    ch_sel_in = 3'd5; vin = 10'h2A7;
    pulse_soc();
    wait_eoc(100, busy, samp);
    check_eq("a_busy", busy, 13);
    check_eq("a_samp", samp, 3);
    check_eq("a_dac", dac_data, 10'h2A7);
    check_eq("a_ch", ch_sel_out, 5);
    step();
    exp_q.push_back({3'd5, 10'h2A7});
    check_eq("a_level", fifo_level, 1);
    check_eq("a_data", data, 13'h16A7);
    check_eq("a_idle", state_dbg, 0);
    check_eq("a_eoc_pulse", eoc, 0);
    pop_check("a_pop");
    check_eq("a_empty", fifo_empty, 1);

    // clkdiv=3: every tick spans 4 cycles, (2+1+10)*4 busy cycles.
    clkdiv = 8'd3; ch_sel_in = 3'd2; vin = 10'h155;
    pulse_soc();
    wait_eoc(400, busy, samp);
    check_eq("b_busy", busy, 52);
    check_eq("b_samp", samp, 12);
    check_eq("b_dac", dac_data, 10'h155);
    step();
    exp_q.push_back({3'd2, 10'h155});
    pop_check("b_pop");
    clkdiv = 8'd0;

    // Sequencer: ch0, ch1, ch2, ch3+stop from a single soc.
    seq_en = 1'b1; vin = 10'h0F0;
    for (int k = 0; k < SEQ_N; k++) seq[k*4 +: 4] = {1'b0, 3'd7};
    seq[0 +: 4] = {1'b0, 3'd0};
    seq[4 +: 4] = {1'b0, 3'd1};
    seq[8 +: 4] = {1'b0, 3'd2};
    seq[12 +: 4] = {1'b1, 3'd3};
    pulse_soc();
    cnt = 0;
    for (int c = 0; c < 150; c++) begin
      if (eoc) cnt++;
      step();
    end
    for (int k = 0; k < 4; k++) exp_q.push_back({3'(k), 10'h0F0});
    check_eq("c_eoc_count", cnt, 4);
    check_eq("c_level", fifo_level, 4);
    check_eq("c_idle", state_dbg, 0);
    for (int k = 0; k < 4; k++) pop_check("c_tag");

    // Free-running sequencer, no stop bits: fill, overrun, push+pop when full.
    vin = 10'h3C5;
    for (int k = 0; k < SEQ_N; k++) seq[k*4 +: 4] = {1'b0, 3'(k)};
    pulse_soc();
    for (int n = 0; n < 16; n++) begin
      wait_eoc(100, busy, samp);
      exp_q.push_back({3'(n % 8), 10'h3C5});
      step();
    end
    check_eq("d_level16", fifo_level, 16);
    check_eq("d_full", fifo_full, 1);
    check_eq("d_ovf0", ovf, 0);
    wait_eoc(100, busy, samp);
    check_eq("d_wrap_ch", ch_sel_out, 0);
    step();
    check_eq("d_ovf_set", ovf, 1);
    check_eq("d_level_drop", fifo_level, 16);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_eq("d_ovf_clr", ovf, 0);
    wait_eoc(100, busy, samp);
    rd = 1'b1;
    step();
    rd = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({3'd1, 10'h3C5});
    check_eq("d_pushpop_level", fifo_level, 16);
    check_eq("d_pushpop_ovf", ovf, 0);
    check_eq("d_pushpop_head", data, exp_q[0]);
    wait_eoc(100, busy, samp);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_eq("d_set_wins", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_eq("d_ovf_clr2", ovf, 0);
    en = 1'b0;
    step();
    check_eq("d_abort_idle", state_dbg, 0);
    check_eq("d_abort_sample_n", sample_n, 1);
    en = 1'b1; seq_en = 1'b0;
    step();

    // Drain with threshold 5 watching fifo_above, then rd on empty.
    while (exp_q.size() > 0) begin
      check_eq("e_level", fifo_level, exp_q.size());
      check_eq("e_above", fifo_above, (exp_q.size() > 5));
      pop_check("e_drain");
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    check_eq("e_rd_empty_level", fifo_level, 0);
    check_eq("e_rd_empty_flag", fifo_empty, 1);
    check_eq("e_rd_empty_data", data, 0);

    // en=0 mid-CONVERT.
    ch_sel_in = 3'd6; vin = 10'h011;
    pulse_soc();
    wait_eoc(100, busy, samp);
    step();
    exp_q.push_back({3'd6, 10'h011});
    ch_sel_in = 3'd4; vin = 10'h200;
    pulse_soc();
    step_n(6);
    check_eq("f_in_convert", state_dbg, 2);
    en = 1'b0;
    step();
    check_eq("f_idle", state_dbg, 0);
    check_eq("f_sample_n", sample_n, 1);
    check_eq("f_dac", dac_data, 0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (eoc) cnt++;
      step();
    end
    check_eq("f_no_eoc", cnt, 0);
    check_eq("f_level", fifo_level, 1);
    check_eq("f_head", data, exp_q[0]);
    en = 1'b1;
    step();

    // Asynchronous reset mid-CONVERT.
    ch_sel_in = 3'd3; vin = 10'h1FF;
    pulse_soc();
    step_n(6);
    check_eq("g_in_convert", state_dbg, 2);
    rst_n = 1'b0;
    #1;
    check_reset_state("g");
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    step_n(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
